// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the injection-side blocks.
//   FLIT_W    : flit width in bits
//   flit_t    : opaque flit type, stored and forwarded unmodified
//   INJ_DEPTH : number of words in each ROM traffic injector, shared by all
//               traffic sets (tornado/uniform) so they agree on burst length
package noc_pkg;

    localparam int FLIT_W    = 20;
    localparam int INJ_DEPTH = 30;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO for flits.
//   clk, rst   : clock, synchronous active-high reset (pointers only)
//   wr_en      : write wr_data at the tail; caller guarantees space
//                (or a same-cycle read when full)
//   rd_en      : advance the head; caller guarantees not empty
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : derived from wrap-bit pointers
//   occupancy  : entries stored, 0..DEPTH
module sync_fifo_fwft
    import noc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  flit_t                    wr_data,
    input  logic                     rd_en,
    output flit_t                    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    flit_t          mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Contents are deliberately left uncleared on reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data   = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Modulo 2*DEPTH difference; the wrap bit makes DEPTH representable.
    assign occupancy = wr_ptr - rd_ptr;

endmodule

// File: rtl/inj_flit_queue.sv
// Injection-side flit queue between a ROM traffic injector and the router
// local input port.
//   clk, rst      : clock, synchronous active-high reset
//   src_enable    : registered throttle to the injector enable
//   in_data/valid : flit stream from the injector, no backpressure
//   out_data/valid/ready : FWFT valid/ready handshake to the router
//   occupancy     : entries currently buffered
//   overflow      : sticky, set on any dropped flit
//   drop_cnt      : dropped flits, saturating at 255
//   acc_cnt       : flits written, wrapping
//   fwd_cnt       : flits handed to the router, wrapping
module inj_flit_queue
    import noc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKID  = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     src_enable,
    input  logic [FLIT_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [CNT_W-1:0]         acc_cnt,
    output logic [CNT_W-1:0]         fwd_cnt
);

    localparam int OW = $clog2(DEPTH) + 1;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           drop;
    logic [OW-1:0]  occ_next;
    logic [OW-1:0]  free_next;
    flit_t          head;

    sync_fifo_fwft #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (push),
        .wr_data   (in_data),
        .rd_en     (pop),
        .rd_data   (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign out_valid = !empty;
    assign out_data  = head;

    // A same-cycle pop frees the slot the incoming flit lands in, so a full
    // queue still accepts when the router drains it.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign occ_next  = occupancy + OW'(push) - OW'(pop);
    assign free_next = OW'(DEPTH) - occ_next;

    // Throttle looks at the post-edge occupancy; SKID slots absorb the flit
    // already in flight through the injector's output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_enable <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            acc_cnt    <= '0;
            fwd_cnt    <= '0;
        end else begin
            src_enable <= (free_next > OW'(SKID));
            if (push) acc_cnt <= acc_cnt + CNT_W'(1);
            if (pop)  fwd_cnt <= fwd_cnt + CNT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inj_flit_queue.sv
// Self-checking bench for inj_flit_queue: a model injector plus a queue-based
// reference model of the buffer, counters and throttle.
module tb_inj_flit_queue;
    import noc_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         src_enable;
    flit_t        in_data;
    logic         in_valid;
    flit_t        out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   occupancy;
    logic         overflow;
    logic [7:0]   drop_cnt;
    logic [15:0]  acc_cnt;
    logic [15:0]  fwd_cnt;

    inj_flit_queue #(.DEPTH(DEPTH), .SKID(SKID), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_enable (src_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .acc_cnt    (acc_cnt),
        .fwd_cnt    (fwd_cnt)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;

    // reference model
    flit_t  q[$];
    int     m_acc, m_fwd, m_drop;
    bit     m_ovf;

    // model injector and forced-flit source
    flit_t  rom [40];
    int     inj_len;
    int     inj_addr;
    bit     en_prev;
    int     force_left;
    int     force_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom_seq();
        for (int i = 0; i < 40; i++) rom[i] = 20'h02010 + flit_t'(i * 16);
        inj_len = INJ_DEPTH;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        in_valid  = 1'b1;                 // must be ignored
        in_data   = flit_t'($urandom);
        out_ready = 1'b1;
        @(posedge clk); #1;
        q.delete();
        m_acc = 0; m_fwd = 0; m_drop = 0; m_ovf = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_acc", acc_cnt, 0);
        chk("rst_fwd", fwd_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_src_enable", src_enable, 0);
        rst        = 1'b0;
        in_valid   = 1'b0;
        en_prev    = 1'b0;
        inj_addr   = 0;
        force_left = 0;
    endtask

    // One clock cycle: drive inputs, check head, advance, check registered state.
    task automatic cyc(input bit rdy);
        bit full_m, pop_m, push_m;
        if (force_left > 0) begin
            in_valid = 1'b1;
            in_data  = 20'h0A000 + flit_t'(force_seq);
            force_seq++;
            force_left--;
        end else if (en_prev && inj_addr < inj_len) begin
            in_valid = 1'b1;
            in_data  = rom[inj_addr];
            inj_addr++;
        end else begin
            in_valid = 1'b0;
            in_data  = flit_t'($urandom);
        end
        out_ready = rdy;
        #1;
        chk("out_valid", out_valid, (q.size() != 0));
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        full_m = (q.size() == DEPTH);
        pop_m  = (q.size() != 0) && rdy;
        push_m = in_valid && (!full_m || pop_m);
        @(posedge clk); #1;
        if (pop_m) begin void'(q.pop_front()); m_fwd++; end
        if (push_m) begin
            q.push_back(in_data);
            m_acc++;
        end else if (in_valid) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        chk("occupancy", occupancy, q.size());
        chk("acc_cnt", acc_cnt, m_acc & 16'hFFFF);
        chk("fwd_cnt", fwd_cnt, m_fwd & 16'hFFFF);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("src_enable", src_enable, ((DEPTH - q.size()) > SKID));
        en_prev = src_enable;
    endtask

    initial begin
        int n;
        force_seq = 0;
        load_rom_seq();

        // basic flow
        reset_dut();
        n = 0;
        while (m_fwd < 30 && n < 300) begin cyc(1'b1); n++; end
        chk("basic_timeout", (n < 300), 1);
        chk("basic_acc", acc_cnt, 30);
        chk("basic_fwd", fwd_cnt, 30);
        chk("basic_drop", drop_cnt, 0);

        // backpressure
        reset_dut();
        repeat (60) cyc(1'b0);
        chk("bp_occ_range", (occupancy >= 4'd6 && occupancy <= 4'd8), 1);
        chk("bp_src_enable", src_enable, 0);
        chk("bp_drop", drop_cnt, 0);
        n = 0;
        while (m_fwd < 30 && n < 300) begin cyc(1'b1); n++; end
        chk("bp_timeout", (n < 300), 1);
        chk("bp_fwd", fwd_cnt, 30);

        // forced overflow
        inj_len = 0;
        reset_dut();
        force_left = 11;
        repeat (11) cyc(1'b0);
        chk("ovf_drop", drop_cnt, 3);
        chk("ovf_flag", overflow, 1);
        chk("ovf_occ", occupancy, 8);
        repeat (12) cyc(1'b1);
        chk("ovf_fwd", fwd_cnt, 8);
        chk("ovf_empty", out_valid, 0);

        // push and pop at full
        reset_dut();
        force_left = 8;
        repeat (8) cyc(1'b0);
        chk("pp_full_occ", occupancy, 8);
        force_left = 1;
        cyc(1'b1);
        chk("pp_occ", occupancy, 8);
        chk("pp_drop", drop_cnt, 0);
        repeat (10) cyc(1'b1);
        chk("pp_fwd", fwd_cnt, 9);

        // wrap-around with random ready
        for (int i = 0; i < 40; i++) rom[i] = flit_t'($urandom);
        inj_len = 40;
        reset_dut();
        n = 0;
        while (m_fwd < 40 && n < 2000) begin cyc(1'($urandom_range(0, 1))); n++; end
        chk("wrap_timeout", (n < 2000), 1);
        chk("wrap_fwd", fwd_cnt, 40);
        chk("wrap_drop", drop_cnt, 0);

        // mid-burst reset
        load_rom_seq();
        reset_dut();
        n = 0;
        while (m_acc < 10 && n < 300) begin cyc(m_acc < 7); n++; end
        chk("mid_timeout", (n < 300), 1);
        chk("mid_buffered", (occupancy >= 4'd3), 1);
        reset_dut();
        cyc(1'b1);
        chk("mid_en_back", src_enable, 1);
        chk("mid_occ", occupancy, 0);
        n = 0;
        while (m_fwd < 30 && n < 300) begin cyc(1'b1); n++; end
        chk("mid_resume_fwd", fwd_cnt, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inj_flit_queue.md
# inj_flit_queue

Injection-side flit queue sitting directly downstream of the per-node ROM traffic injectors (`dataout_buf_*`). It captures the 20-bit flits they stream on `dataout`/`out_valid` and buffers them in a small FIFO. It throttles the injector through its `enable` input and presents flits to the router local input port with a valid/ready handshake. It also keeps accepted/forwarded/dropped counters for the tornado/uniform traffic experiments.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥4.
- `SKID`, 2: free-slot headroom kept when granting `src_enable`; covers the source's registered output.
- `CNT_W`, 16: width of the accepted/forwarded counters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `src_enable`  out  1  to injector `enable`; registered.
- `in_data`  in  20  from injector `dataout`.
- `in_valid`  in  1  from injector `out_valid`; no backpressure on this path.
- `out_data`  out  20  flit to router local port.
- `out_valid`  out  1  head flit present.
- `out_ready`  in  1  router accepts the flit this cycle.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently stored.
- `overflow`  out  1  sticky; set on any dropped flit.
- `drop_cnt`  out  8  dropped flits, saturating at 255.
- `acc_cnt`  out  CNT_W  flits written, wrapping.
- `fwd_cnt`  out  CNT_W  flits handed to the router, wrapping.

## Operation
- Flits are opaque: 20 bits, stored and forwarded unmodified. The value 20'h00000 is a legal flit.
- Push: `in_valid`=1 and (not full, or a pop in the same cycle). Flit is written at `wr_ptr`, and `acc_cnt` increments.
- Drop: `in_valid`=1, full, and no same-cycle pop. The flit is discarded, `overflow` is set, and `drop_cnt` increments and saturates.
- Pop: `out_valid` & `out_ready`. `rd_ptr` advances and `fwd_cnt` increments.
- Push and pop in the same cycle leave occupancy unchanged. This holds at full and at a non-empty level. Push into an empty queue with no pop raises occupancy to 1.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. Full is `wr_ptr`/`rd_ptr` low bits equal with the MSBs differing. Empty is all bits equal. Wrap is natural modulo 2·DEPTH.
- Output is first-word-fall-through: `out_data` = mem[`rd_ptr`], and `out_valid` = !empty.
- `src_enable` next value = (DEPTH − occupancy_next) > SKID, where occupancy_next is the occupancy after this cycle's push/pop.
- With a compliant source (one registered cycle from `enable` to `out_valid`), no flit is ever dropped.
- When `src_enable` is low, the injector holds its address. Deasserting and reasserting `src_enable` resumes the burst with no loss.
- Reset (any cycle, including mid-burst):
  - Pointers, occupancy, all counters, `overflow` and `src_enable` go to 0.
  - `out_valid` goes to 0, and `out_data` is don't-care while `out_valid`=0.
  - FIFO contents are not cleared.
  - A flit presented in the reset cycle is ignored.

## Timing
- Flit accepted at edge t is visible on `out_valid`/`out_data` after edge t: one cycle of latency when empty.
- `src_enable` rises at the first edge with `rst`=0.
- `occupancy`, `overflow`, `drop_cnt`, `acc_cnt` and `fwd_cnt` are registered. They reflect the events of the previous edge.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `noc_pkg`: `FLIT_W`=20 and the `flit_t` typedef; also the injector `DEPTH`, so traffic sets share one definition.
- One sub-module, `sync_fifo_fwft`: memory, pointers, full/empty and occupancy.
- Top level: drop/counter logic and `src_enable` generation.

## Test plan
- Basic flow: reset, hold `out_ready`=1, and drive the 30-word ROM sequence 20'h02010…20'h021E0 through a model injector.
  - Output order matches the ROM sequence.
  - `acc_cnt` = `fwd_cnt` = 30, and `drop_cnt` = 0.
- Backpressure: `out_ready`=0 throughout.
  - Occupancy settles at DEPTH−SKID (6) to DEPTH, and `src_enable`=0.
  - `drop_cnt`=0.
  - After releasing `out_ready`, all 30 flits arrive in order.
- Forced overflow: ignore `src_enable`, fill with 8 flits plus 3 extra, `out_ready`=0.
  - `drop_cnt`=3 and `overflow`=1.
  - Output is the first 8 flits only.
- Push and pop at full: DEPTH=8 full, then `in_valid` and `out_ready` both 1 for one cycle.
  - Occupancy stays 8 and no drop occurs.
  - The new flit is output 8th.
- Wrap-around: stream 40 flits with random `out_ready` (50%).
  - Pointers wrap several times with no loss and no reorder.
- Mid-burst reset: assert `rst` after 10 flits with 4 buffered.
  - Next cycle: `out_valid`=0, `occupancy`=0, all counters 0, `src_enable`=0.
  - `src_enable` returns to 1 one cycle after `rst` falls.
